// File: rtl/pipa_cdu_cntr_req.sv
// PIPA/CDU counter-request sequencer.
// Synchronizes and edge-detects the twelve plus/minus increment lines,
// keeps a saturating signed backlog per channel, and issues one
// PINC/MINC request at a time to the counter-cycle logic in fixed priority.
module pipa_cdu_cntr_req #(
    parameter int NCH    = 6,
    parameter int SATMAX = 3
) (
    input  logic           CLOCK,
    input  logic           rst_,
    input  logic           PIPXP,
    input  logic           PIPXM,
    input  logic           PIPYP,
    input  logic           PIPYM,
    input  logic           PIPZP,
    input  logic           PIPZM,
    input  logic           CDUXP,
    input  logic           CDUXM,
    input  logic           CDUYP,
    input  logic           CDUYM,
    input  logic           CDUZP,
    input  logic           CDUZM,
    input  logic           CTACK,
    input  logic           GOJAM,
    input  logic           CLRLOST,
    output logic           CTREQ,
    output logic [2:0]     CTSEL,
    output logic           PINC,
    output logic           MINC,
    output logic [NCH-1:0] LOST,
    output logic           BUSY_
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Line 2*ch is the plus pulse of channel ch, line 2*ch+1 the minus pulse.
    logic [2*NCH-1:0] raw;
    logic [2*NCH-1:0] sync1, sync2, sync3;
    logic [2*NCH-1:0] inc;

    logic [NCH-1:0][2:0] pend, pend_nxt;
    logic [NCH-1:0]      ovf;
    logic                ack_fire;

    state_t     state, state_nxt;
    logic [2:0] sel_nxt;
    logic       pinc_nxt, minc_nxt;
    logic [2:0] pick;
    logic       found;

    assign raw = {CDUZM, CDUZP, CDUYM, CDUYP, CDUXM, CDUXP,
                  PIPZM, PIPZP, PIPYM, PIPYP, PIPXM, PIPXP};

    // Two-stage synchronizer, edge-detect stage and registered one-cycle edge event.
    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
            inc   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            sync3 <= sync2;
            inc   <= sync2 & ~sync3;
        end
    end

    // An ack only counts while a request is outstanding; GOJAM overrides it.
    assign ack_fire = (state == S_REQ) && CTACK && !GOJAM;

    // Backlog update: edge delta and ack delta are summed before clamping.
    always_comb begin
        int sum;
        sum      = 0;
        pend_nxt = pend;
        ovf      = '0;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            sum = int'($signed(pend[ch]));
            if (inc[2*ch] && !inc[2*ch+1]) begin
                sum = sum + 1;
            end else if (!inc[2*ch] && inc[2*ch+1]) begin
                sum = sum - 1;
            end
            if (ack_fire && (CTSEL == 3'(ch))) begin
                if (PINC) begin
                    sum = sum - 1;
                end else if (MINC) begin
                    sum = sum + 1;
                end
            end
            if (sum > SATMAX) begin
                pend_nxt[ch] = 3'(SATMAX);
                ovf[ch]      = !GOJAM;
            end else if (sum < -SATMAX) begin
                pend_nxt[ch] = 3'(-SATMAX);
                ovf[ch]      = !GOJAM;
            end else begin
                pend_nxt[ch] = 3'(sum);
            end
        end
    end

    // Backlog and sticky overflow flags; a new overflow beats CLRLOST.
    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            pend <= '0;
            LOST <= '0;
        end else begin
            pend <= GOJAM ? '0 : pend_nxt;
            LOST <= (CLRLOST ? '0 : LOST) | ovf;
        end
    end

    // FSM state and latched request fields.
    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            state <= S_IDLE;
            CTSEL <= '0;
            PINC  <= 1'b0;
            MINC  <= 1'b0;
        end else begin
            state <= state_nxt;
            CTSEL <= sel_nxt;
            PINC  <= pinc_nxt;
            MINC  <= minc_nxt;
        end
    end

    // Next state: pick lowest nonzero channel in IDLE, hold fields through REQ.
    always_comb begin
        state_nxt = state;
        sel_nxt   = CTSEL;
        pinc_nxt  = PINC;
        minc_nxt  = MINC;
        found     = 1'b0;
        pick      = '0;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            if (!found && (pend[ch] != '0)) begin
                found = 1'b1;
                pick  = 3'(ch);
            end
        end
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_nxt = S_REQ;
                    sel_nxt   = pick;
                    pinc_nxt  = !pend[pick][2];
                    minc_nxt  = pend[pick][2];
                end
            end
            S_REQ: begin
                if (CTACK) begin
                    state_nxt = S_GAP;
                    pinc_nxt  = 1'b0;
                    minc_nxt  = 1'b0;
                end
            end
            S_GAP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (GOJAM) begin
            state_nxt = S_IDLE;
            pinc_nxt  = 1'b0;
            minc_nxt  = 1'b0;
        end
    end

    assign CTREQ = (state == S_REQ);
    assign BUSY_ = !((|pend) || CTREQ);

endmodule
